// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
//   Shared definitions for the 1RW/1R byte-masked SRAM model.
//   - clog2       : address width helper, never returns less than 1
//   - clrState_t  : states of the post-reset clear sequencer
//   - merge       : byte-masked merge of a new word over an old word
//
//   merge works on a fixed maximum width so one function serves every
//   DATA_WIDTH; callers size-cast their operands in and the result back out.
// ---------------------------------------------------------------------------
package sram_pkg;

  localparam int MERGE_MAX_BYTES = 128;
  localparam int MERGE_MAX_BITS  = MERGE_MAX_BYTES * 8;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } clrState_t;

  // Smallest width able to address 'value' words. A single-word memory still
  // gets a one-bit address so that no port collapses to zero width.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Byte lane i of the result comes from newWord when mask[i] is set,
  // otherwise from oldWord.
  function automatic logic [MERGE_MAX_BITS-1:0] merge(
    input logic [MERGE_MAX_BITS-1:0]  oldWord,
    input logic [MERGE_MAX_BITS-1:0]  newWord,
    input logic [MERGE_MAX_BYTES-1:0] mask
  );
    logic [MERGE_MAX_BITS-1:0] result;
    result = oldWord;
    for (int i = 0; i < MERGE_MAX_BYTES; i++) begin
      if (mask[i]) begin
        result[8*i +: 8] = newWord[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// ---------------------------------------------------------------------------
// sram_clear_seq
//   Post-reset sequencer. After reset it walks the clear address from 0 to
//   DEPTH-1, one word per clock, asking the top level to write INIT_VAL to
//   each address, then reports the memory ready. With CLEAR_ON_RESET=0 the
//   clear walk is skipped and the memory is ready one clock after reset.
//   Reset asserted mid-walk aborts it; the next walk starts again at 0.
//
// Ports
//   i_clk       clock (posedge)
//   i_rstN      asynchronous active-low reset
//   o_clrWe     high while a clear write should be issued this cycle
//   o_clrAddr   address of the clear write
//   o_initDone  high once the sequencer has reached READY
// ---------------------------------------------------------------------------
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int ADDR_WIDTH     = clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rstN,
  output logic                  o_clrWe,
  output logic [ADDR_WIDTH-1:0] o_clrAddr,
  output logic                  o_initDone
);

  clrState_t             r_state;
  clrState_t             w_nextState;
  logic [ADDR_WIDTH-1:0] r_clrAddr;
  logic [ADDR_WIDTH-1:0] w_nextClrAddr;
  logic                  w_lastAddr;

  assign w_lastAddr = (r_clrAddr == ADDR_WIDTH'(DEPTH - 1));
  assign o_clrAddr  = r_clrAddr;

  // State and clear-address registers; reset always returns to the start of
  // the walk so an aborted clear never resumes half way.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_state   <= ST_RESET;
      r_clrAddr <= '0;
    end else begin
      r_state   <= w_nextState;
      r_clrAddr <= w_nextClrAddr;
    end
  end

  // Next state and outputs. RESET lasts exactly one clock after reset is
  // released; CLEAR lasts DEPTH clocks, issuing one write per clock; READY is
  // terminal until the next reset.
  always_comb begin
    w_nextState   = r_state;
    w_nextClrAddr = r_clrAddr;
    o_clrWe       = 1'b0;
    o_initDone    = 1'b0;
    unique case (r_state)
      ST_RESET: begin
        w_nextClrAddr = '0;
        w_nextState   = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      end
      ST_CLEAR: begin
        o_clrWe = 1'b1;
        if (w_lastAddr) begin
          w_nextState   = ST_READY;
          w_nextClrAddr = '0;
        end else begin
          w_nextClrAddr = r_clrAddr + 1'b1;
        end
      end
      ST_READY: begin
        o_initDone = 1'b1;
      end
      default: begin
        w_nextState = ST_RESET;
      end
    endcase
  end

endmodule

// File: rtl/sram_1rw1r_bm_param.sv
// ---------------------------------------------------------------------------
// sram_1rw1r_bm_param
//   Behavioural SRAM with one read/write port (0) and one read-only port (1),
//   per-byte write mask, post-reset clear, read-during-write forwarding and
//   out-of-range detection. Requests are captured on the rising edge and the
//   array is accessed on the following falling edge, so read data appears
//   half a cycle after the request and is sampled on the next rising edge.
//
// Parameters
//   DATA_WIDTH      word width, multiple of 8
//   DEPTH           number of words, any value >= 1
//   CLEAR_ON_RESET  1: fill every word with INIT_VAL after reset
//   INIT_VAL        fill value
//   RDW_NEW         1: port 1 sees the merged new word on a same-address
//                   collision with a port-0 write; 0: it sees the old word
//
// Ports
//   clk0, rstb0               clock, asynchronous active-low reset
//   init_done                 memory accepts requests
//   csb0/web0/wmask0/addr0/din0 -> dout0/dout0_vld   read/write port
//   csb1/addr1                -> dout1/dout1_vld     read-only port
//   addr_err                  one-cycle pulse for an accepted addr >= DEPTH
// ---------------------------------------------------------------------------
module sram_1rw1r_bm_param
  import sram_pkg::*;
#(
  parameter  int                    DATA_WIDTH     = 32,
  parameter  int                    DEPTH          = 256,
  parameter  bit                    CLEAR_ON_RESET = 1'b1,
  parameter  logic [DATA_WIDTH-1:0] INIT_VAL       = '0,
  parameter  bit                    RDW_NEW        = 1'b1,
  localparam int                    ADDR_WIDTH     = clog2(DEPTH),
  localparam int                    NUM_BYTES      = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  output logic                  init_done,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_BYTES-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_vld,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_vld,
  output logic                  addr_err
);

  // Clear sequencer
  logic                  w_clrWe;
  logic [ADDR_WIDTH-1:0] w_clrAddr;
  logic                  w_initDone;

  sram_clear_seq #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .ADDR_WIDTH     (ADDR_WIDTH)
  ) u_clearSeq (
    .i_clk      (clk0),
    .i_rstN     (rstb0),
    .o_clrWe    (w_clrWe),
    .o_clrAddr  (w_clrAddr),
    .o_initDone (w_initDone)
  );

  assign init_done = w_initDone;

  // Captured request
  logic                  r_csb0;
  logic                  r_web0;
  logic [NUM_BYTES-1:0]  r_wmask0;
  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [DATA_WIDTH-1:0] r_din0;
  logic                  r_csb1;
  logic [ADDR_WIDTH-1:0] r_addr1;

  // Storage and outputs
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout0;
  logic                  r_dout0Vld;
  logic [DATA_WIDTH-1:0] r_dout1;
  logic                  r_dout1Vld;
  logic                  r_addrErr;

  // Falling-edge access decode
  logic                  w_acc0;
  logic                  w_acc1;
  logic                  w_oor0;
  logic                  w_oor1;
  logic [ADDR_WIDTH-1:0] w_idx0;
  logic [ADDR_WIDTH-1:0] w_idx1;
  logic [DATA_WIDTH-1:0] w_word0;
  logic [DATA_WIDTH-1:0] w_word1;
  logic [DATA_WIDTH-1:0] w_wrWord;
  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_rdData0;
  logic [DATA_WIDTH-1:0] w_rdData1;

  // Request capture. While the memory is not ready, user requests are
  // dropped and port 0 is borrowed by the clear sequencer instead, which
  // always writes a full word.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      r_csb0   <= 1'b1;
      r_web0   <= 1'b1;
      r_wmask0 <= '0;
      r_addr0  <= '0;
      r_din0   <= '0;
      r_csb1   <= 1'b1;
      r_addr1  <= '0;
    end else if (w_initDone) begin
      r_csb0   <= csb0;
      r_web0   <= web0;
      r_wmask0 <= wmask0;
      r_addr0  <= addr0;
      r_din0   <= din0;
      r_csb1   <= csb1;
      r_addr1  <= addr1;
    end else begin
      r_csb0   <= ~w_clrWe;
      r_web0   <= 1'b0;
      r_wmask0 <= '1;
      r_addr0  <= w_clrAddr;
      r_din0   <= INIT_VAL;
      r_csb1   <= 1'b1;
    end
  end

  // Access decode. Out-of-range addresses are redirected to index 0 for the
  // array lookup so the array is never indexed past its end; their read data
  // is forced to zero and their writes are suppressed. On a same-address
  // collision w_wrWord is exactly the merged word port 1 may forward.
  always_comb begin
    w_acc0    = ~r_csb0;
    w_acc1    = ~r_csb1;
    w_oor0    = (32'(r_addr0) >= 32'(DEPTH));
    w_oor1    = (32'(r_addr1) >= 32'(DEPTH));
    w_idx0    = w_oor0 ? '0 : r_addr0;
    w_idx1    = w_oor1 ? '0 : r_addr1;
    w_word0   = r_mem[w_idx0];
    w_word1   = r_mem[w_idx1];
    w_wrWord  = DATA_WIDTH'(merge(MERGE_MAX_BITS'(w_word0),
                                  MERGE_MAX_BITS'(r_din0),
                                  MERGE_MAX_BYTES'(r_wmask0)));
    w_wr0     = w_acc0 & ~r_web0 & ~w_oor0;
    w_rd0     = w_acc0 & r_web0;
    w_rd1     = w_acc1;
    w_collide = w_wr0 & ~w_oor1 & (r_addr0 == r_addr1);
    w_rdData0 = w_oor0 ? '0 : w_word0;
    w_rdData1 = w_word1;
    if (w_oor1) begin
      w_rdData1 = '0;
    end else if (w_collide && RDW_NEW) begin
      w_rdData1 = w_wrWord;
    end
  end

  // Array write on the falling edge. The array itself is never reset; only
  // the clear walk initialises it.
  always_ff @(negedge clk0) begin
    if (w_wr0) begin
      r_mem[w_idx0] <= w_wrWord;
    end
  end

  // Read outputs on the falling edge. Data holds when no read is accepted,
  // valid only reflects the current cycle, and addr_err is a one-cycle pulse.
  always_ff @(negedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      r_dout0    <= '0;
      r_dout0Vld <= 1'b0;
      r_dout1    <= '0;
      r_dout1Vld <= 1'b0;
      r_addrErr  <= 1'b0;
    end else begin
      r_dout0Vld <= w_rd0;
      r_dout1Vld <= w_rd1;
      if (w_rd0) begin
        r_dout0 <= w_rdData0;
      end
      if (w_rd1) begin
        r_dout1 <= w_rdData1;
      end
      r_addrErr <= (w_acc0 & w_oor0) | (w_acc1 & w_oor1);
    end
  end

  assign dout0     = r_dout0;
  assign dout0_vld = r_dout0Vld;
  assign dout1     = r_dout1;
  assign dout1_vld = r_dout1Vld;
  assign addr_err  = r_addrErr;

endmodule
